spill_splitter: RTL
===================

// Module: spill_splitter
// PURPOSE
//  Downstream consumer of the coalescer's splitter tasks. Takes the coal_id of one splitter task.
//  Burst-reads that slot's TASKS_PER_SPLITTER spilled tasks from memory and re-issues them on the
//  task-enqueue path. Counts finished slots per chunk in the scratchpad. When a chunk's last slot
//  is drained, pushes the chunk index back onto the shared free stack under the stack lock.
// PARAMETERS
//  TASK_W              128  spilled task width in bits (power of 2, <= DATA_W)
//  DATA_W              512  memory data bus width
//  TASKS_PER_SPLITTER  8    tasks per slot (burst length)
//  LOG_SPLITTERS_PER_CHUNK 2 slots per chunk = 2**this
//  LOG_CHUNK_BYTES     7    log2 bytes per slot in spill area
//  STACK_ENTRY_W       32   free-stack entry width in bits
// PORTS
//  clk            in   1       clock
//  rstn           in   1       async active-low reset
//  start          in   1       enable; low = accept no new splitter task
//  cfg_spill_base in   64      spill task area base address
//  cfg_stack_base in   64      free-stack base address
//  cfg_scratch_base in 64      per-chunk counter array base (16b per chunk)
//  cfg_stack_ptr_addr in 64    address of 16b free-stack pointer
//  in_valid/in_ready in/out 1  splitter-task handshake
//  in_coal_id     in   16      slot id (chunk = coal_id>>LOG_SPLITTERS_PER_CHUNK)
//  out_valid/out_ready out/in 1 task re-enqueue handshake
//  out_task       out  TASK_W  re-enqueued task
//  m_ar{valid,ready,addr[63:0],len[7:0],size[2:0]}  read address channel (id always 0)
//  m_r{valid,ready,data[DATA_W-1:0],last}           read data channel
//  m_aw{valid,ready,addr,len,size}, m_w{valid,ready,data,strb,last}, m_b{valid,ready}  write channels
//  stack_lock_out out 1        this block holds the free-stack lock
//  stack_lock_in  in  1        coalescer holds the free-stack lock
//  err_underflow  out 1        sticky: push attempted with stack_ptr==0
//  busy           out 1        FSM not in IDLE
// BEHAVIOUR
//  Reset: all valids, in_ready, stack_lock_out, err_underflow, busy = 0; FSM=IDLE; regs cleared.
//  One outstanding memory transaction; m_bready=1 always; single-beat accesses use len=0.
//  Writes: awvalid+wvalid raised together; each drops after its own handshake.
//    FSM leaves a write state once both channels are done, then waits m_bvalid.
//  FSM:
//   IDLE: in_ready=start. On handshake, latch coal_id -> RD_SLOT.
//   RD_SLOT: araddr=spill_base+(coal_id<<LOG_CHUNK_BYTES), arlen=TASKS_PER_SPLITTER-1,
//     arsize=log2(TASK_W/8); on arready -> STREAM.
//   STREAM: out_valid=m_rvalid, out_task=m_rdata[TASK_W-1:0], m_rready=out_ready
//     (zero-latency pass-through, no buffering). Beat consumed on m_rvalid&out_ready.
//     On last beat (m_rlast) -> RD_CNT.
//   RD_CNT: read 16b at scratch_base+(chunk<<1) -> cnt.
//   WR_CNT: write cnt+1, or 0 if cnt+1==2**LOG_SPLITTERS_PER_CHUNK (wrap).
//     After B: wrapped -> GRAB, else -> IDLE.
//   GRAB: if !stack_lock_in, set lock_out -> CHECK.
//   CHECK: splitter has priority on a simultaneous grab; keep lock -> RD_PTR.
//   RD_PTR: read 16b stack_ptr.
//     ptr==0: set err_underflow -> RELEASE (no push). Else -> WR_TOP.
//   WR_TOP: write chunk (STACK_ENTRY_W bits) at stack_base+((ptr-1)<<log2(STACK_ENTRY_W/8)).
//   WR_PTR: write ptr-1; after B -> RELEASE.
//   RELEASE: lock_out<=0 -> IDLE.
//  Address arithmetic: 64b unsigned, no overflow check. Counter and ptr are 16b.
//  start deasserted mid-operation: current op runs to IDLE (stack never left half-updated), then stalls.
//  out_ready low: stalls the R channel indefinitely; no tasks dropped or duplicated.
//  Async reset mid-operation: immediate return to reset state, lock released; memory state is
//    software's responsibility.
//  busy=1 in every state except IDLE.
// TESTING
//  coal_id=5, 8 tasks T0..T7 at spill_base+0x280, counter=0 -> out T0..T7 in order; counter becomes 1; no lock taken.
//  out_ready toggling 1/0 every cycle during STREAM -> exactly 8 out handshakes, data intact, m_rready==out_ready each cycle.
//  coal_id=7 (slot 3 of chunk 1), counter=3, ptr=10 -> counter written 0; entry[9]=1; ptr=9; lock high only GRAB..RELEASE.
//  Push path with stack_lock_in held 20 cycles -> no stack access until lock_in drops; lock_out never high while lock_in high on entering GRAB.
//  Wrap with ptr=0 -> err_underflow=1, no stack write, lock released, back to IDLE.
//  rstn pulsed low during STREAM beat 4 -> out_valid, lock_out, busy =0 same cycle; next splitter task processed normally.

Source files
------------

// File: rtl/spill_splitter_if.sv
// Bundle of the splitter-task input, task re-enqueue output and memory channels.
// The master modport is the spill_splitter's view; slave is the environment's.
interface spill_splitter_if #(
    parameter int TASK_W = 128,
    parameter int DATA_W = 512
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_coal_id;

    logic              out_valid;
    logic              out_ready;
    logic [TASK_W-1:0] out_task;

    logic              m_arvalid;
    logic              m_arready;
    logic [63:0]       m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;

    logic              m_rvalid;
    logic              m_rready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rlast;

    logic              m_awvalid;
    logic              m_awready;
    logic [63:0]       m_awaddr;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;

    logic              m_wvalid;
    logic              m_wready;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic              m_wlast;

    logic              m_bvalid;
    logic              m_bready;

    modport master (
        input  in_valid, in_coal_id, output in_ready,
        output out_valid, out_task, input out_ready,
        output m_arvalid, m_araddr, m_arlen, m_arsize, input m_arready,
        input  m_rvalid, m_rdata, m_rlast, output m_rready,
        output m_awvalid, m_awaddr, m_awlen, m_awsize, input m_awready,
        output m_wvalid, m_wdata, m_wstrb, m_wlast, input m_wready,
        input  m_bvalid, output m_bready
    );

    modport slave (
        output in_valid, in_coal_id, input in_ready,
        input  out_valid, out_task, output out_ready,
        input  m_arvalid, m_araddr, m_arlen, m_arsize, output m_arready,
        output m_rvalid, m_rdata, m_rlast, input m_rready,
        input  m_awvalid, m_awaddr, m_awlen, m_awsize, output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast, output m_wready,
        output m_bvalid, input m_bready
    );
endinterface

// File: rtl/spill_splitter.sv
// Drains one spilled splitter slot back onto the task-enqueue path and returns the
// chunk to the shared free stack once its last slot has been drained.
//
// state   | meaning
// IDLE    | waiting for a splitter task (in_ready = start)
// RD_SLOT | issuing the burst read of the slot's spilled tasks
// STREAM  | passing read beats straight through to the task output
// RD_CNT  | reading the chunk's finished-slot counter
// WR_CNT  | writing the incremented (or wrapped) counter
// GRAB    | waiting for the coalescer to release the free-stack lock
// CHECK   | lock taken; splitter wins a simultaneous grab
// RD_PTR  | reading the free-stack pointer
// WR_TOP  | writing the chunk index onto the stack top
// WR_PTR  | writing the decremented stack pointer
// RELEASE | dropping the free-stack lock
module spill_splitter #(
    parameter int TASK_W                  = 128,
    parameter int DATA_W                  = 512,
    parameter int TASKS_PER_SPLITTER      = 8,
    parameter int LOG_SPLITTERS_PER_CHUNK = 2,
    parameter int LOG_CHUNK_BYTES         = 7,
    parameter int STACK_ENTRY_W           = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [63:0]       cfg_spill_base,
    input  logic [63:0]       cfg_stack_base,
    input  logic [63:0]       cfg_scratch_base,
    input  logic [63:0]       cfg_stack_ptr_addr,
    spill_splitter_if.master  bus,
    output logic              stack_lock_out,
    input  logic              stack_lock_in,
    output logic              err_underflow,
    output logic              busy
);
    localparam int STRB_W      = DATA_W / 8;
    localparam int TASK_SIZE   = $clog2(TASK_W / 8);
    localparam int ENTRY_SHIFT = $clog2(STACK_ENTRY_W / 8);
    localparam logic [15:0] SLOTS_PER_CHUNK = 16'(1 << LOG_SPLITTERS_PER_CHUNK);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_SLOT, S_STREAM, S_RD_CNT, S_WR_CNT, S_GRAB,
        S_CHECK, S_RD_PTR, S_WR_TOP, S_WR_PTR, S_RELEASE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] coal_id;
    logic [15:0] cnt;
    logic [15:0] ptr;
    logic        ar_done, aw_done, w_done;

    logic [15:0] chunk;
    logic [15:0] cnt_inc;
    logic [15:0] ptr_dec;
    logic        wrap;
    logic        rd_resp;
    logic        wr_resp;
    logic [63:0] slot_addr, cnt_addr, top_addr;

    assign chunk     = coal_id >> LOG_SPLITTERS_PER_CHUNK;
    assign cnt_inc   = cnt + 16'd1;
    assign ptr_dec   = ptr - 16'd1;
    assign wrap      = (cnt_inc == SLOTS_PER_CHUNK);
    assign slot_addr = cfg_spill_base + (64'(coal_id) << LOG_CHUNK_BYTES);
    assign cnt_addr  = cfg_scratch_base + {47'd0, chunk, 1'b0};
    assign top_addr  = cfg_stack_base + (64'(ptr_dec) << ENTRY_SHIFT);
    assign rd_resp   = ar_done && bus.m_rvalid;
    assign wr_resp   = aw_done && w_done && bus.m_bvalid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.in_valid && start) state_nxt = S_RD_SLOT;
            S_RD_SLOT: if (bus.m_arready) state_nxt = S_STREAM;
            S_STREAM:  if (bus.m_rvalid && bus.out_ready && bus.m_rlast) state_nxt = S_RD_CNT;
            S_RD_CNT:  if (rd_resp) state_nxt = S_WR_CNT;
            S_WR_CNT:  if (wr_resp) state_nxt = wrap ? S_GRAB : S_IDLE;
            S_GRAB:    if (!stack_lock_in) state_nxt = S_CHECK;
            S_CHECK:   state_nxt = S_RD_PTR;
            S_RD_PTR:  if (rd_resp) state_nxt = (bus.m_rdata[15:0] == 16'd0) ? S_RELEASE : S_WR_TOP;
            S_WR_TOP:  if (wr_resp) state_nxt = S_WR_PTR;
            S_WR_PTR:  if (wr_resp) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Narrow accesses are right-justified on the data bus with low-lane strobes.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_task  = bus.m_rdata[TASK_W-1:0];
        bus.m_rready  = 1'b0;
        bus.m_arvalid = 1'b0;
        bus.m_araddr  = 64'd0;
        bus.m_arlen   = 8'd0;
        bus.m_arsize  = 3'd1;
        bus.m_awvalid = 1'b0;
        bus.m_awaddr  = 64'd0;
        bus.m_awlen   = 8'd0;
        bus.m_awsize  = 3'd1;
        bus.m_wvalid  = 1'b0;
        bus.m_wdata   = '0;
        bus.m_wstrb   = STRB_W'(2'b11);
        bus.m_wlast   = 1'b1;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE: bus.in_ready = start;
            S_RD_SLOT: begin
                bus.m_arvalid = 1'b1;
                bus.m_araddr  = slot_addr;
                bus.m_arlen   = 8'(TASKS_PER_SPLITTER - 1);
                bus.m_arsize  = 3'(TASK_SIZE);
            end
            S_STREAM: begin
                bus.out_valid = bus.m_rvalid;
                bus.m_rready  = bus.out_ready;
            end
            S_RD_CNT: begin
                bus.m_arvalid = !ar_done;
                bus.m_araddr  = cnt_addr;
                bus.m_rready  = ar_done;
            end
            S_RD_PTR: begin
                bus.m_arvalid = !ar_done;
                bus.m_araddr  = cfg_stack_ptr_addr;
                bus.m_rready  = ar_done;
            end
            S_WR_CNT: begin
                bus.m_awvalid = !aw_done;
                bus.m_wvalid  = !w_done;
                bus.m_awaddr  = cnt_addr;
                bus.m_wdata   = DATA_W'(wrap ? 16'd0 : cnt_inc);
            end
            S_WR_TOP: begin
                bus.m_awvalid = !aw_done;
                bus.m_wvalid  = !w_done;
                bus.m_awaddr  = top_addr;
                bus.m_awsize  = 3'(ENTRY_SHIFT);
                bus.m_wdata   = DATA_W'(chunk);
                bus.m_wstrb   = STRB_W'({(STACK_ENTRY_W / 8){1'b1}});
            end
            S_WR_PTR: begin
                bus.m_awvalid = !aw_done;
                bus.m_wvalid  = !w_done;
                bus.m_awaddr  = cfg_stack_ptr_addr;
                bus.m_wdata   = DATA_W'(ptr_dec);
            end
            default: ;
        endcase
    end

    assign bus.m_bready = 1'b1;

    // Channel-done flags are scoped to a single state visit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state_nxt != state) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (bus.m_arvalid && bus.m_arready) ar_done <= 1'b1;
            if (bus.m_awvalid && bus.m_awready) aw_done <= 1'b1;
            if (bus.m_wvalid && bus.m_wready)   w_done  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coal_id        <= 16'd0;
            cnt            <= 16'd0;
            ptr            <= 16'd0;
            stack_lock_out <= 1'b0;
            err_underflow  <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.in_valid && start) coal_id <= bus.in_coal_id;
            if (state == S_RD_CNT && rd_resp) cnt <= bus.m_rdata[15:0];
            if (state == S_RD_PTR && rd_resp) begin
                ptr <= bus.m_rdata[15:0];
                if (bus.m_rdata[15:0] == 16'd0) err_underflow <= 1'b1;
            end
            if (state == S_GRAB && !stack_lock_in) stack_lock_out <= 1'b1;
            if (state == S_RELEASE) stack_lock_out <= 1'b0;
        end
    end
endmodule
